// File: rtl/d_c10_tx_if.sv
// Digit handshake bundle for the d_c10 pulse-train transmitter.
// The source drives digit/valid; the transmitter answers with ready.
interface d_c10_tx_if;
  logic [3:0] digit;
  logic       valid;
  logic       ready;

  modport master (output digit, output valid, input ready);
  modport slave  (input digit, input valid, output ready);
endinterface

// File: rtl/d_c10_tx.sv
// Pulse-train transmitter feeding a mod-10 pulse counter.
// A BCD digit N accepted over the handshake becomes N one-cycle pulses,
// separated by GAP low cycles. A shadow copy of the counter state (pos)
// is kept so the sender knows when the receiver's terminal output is high.
module d_c10_tx #(
  parameter int GAP = 1,
  parameter int CW  = 4
) (
  input  logic        clk,
  input  logic        rst,
  d_c10_tx_if.slave   bus,
  input  logic        clr,
  output logic        out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  pos,
  output logic        term
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PULSE = 3'd1,
    S_GAP   = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // With GAP=0 the gap counter is never loaded; keep the load value legal.
  localparam bit         GAP_ZERO = (GAP == 0);
  localparam logic [3:0] GAP_LD   = GAP_ZERO ? 4'd0 : 4'(GAP - 1);

  state_t          r_state;
  logic [CW-1:0]   r_rem;
  logic [3:0]      r_gap;
  logic [3:0]      r_pos;
  logic            r_term;
  logic            r_out;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic            r_ready;
  logic [3:0]      w_pos_inc;
  logic [3:0]      w_pos_nxt;

  // Next shadow count: a pulse leaving this cycle advances it mod 10, clr wins.
  always_comb begin
    w_pos_inc = (r_pos == 4'd9) ? 4'd0 : (r_pos + 4'd1);
    if (clr) begin
      w_pos_nxt = 4'd0;
    end else if (r_state == S_PULSE) begin
      w_pos_nxt = w_pos_inc;
    end else begin
      w_pos_nxt = r_pos;
    end
  end

  // Burst FSM with all outputs registered alongside the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_gap   <= 4'd0;
      r_pos   <= 4'd0;
      r_term  <= 1'b0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_pos  <= w_pos_nxt;
      r_term <= (w_pos_nxt == 4'd9);
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.valid) begin
            r_ready <= 1'b0;
            if (bus.digit == 4'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (bus.digit > 4'd9) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_PULSE;
              r_rem   <= CW'(bus.digit);
              r_out   <= 1'b1;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_PULSE: begin
          // Decide on the pre-decrement value so remaining never wraps.
          r_rem <= r_rem - CW'(1'b1);
          if (r_rem == CW'(1'b1)) begin
            r_state <= S_DONE;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (GAP_ZERO) begin
            r_state <= S_PULSE;
            r_out   <= 1'b1;
          end else begin
            r_state <= S_GAP;
            r_gap   <= GAP_LD;
            r_out   <= 1'b0;
          end
        end
        S_GAP: begin
          if (r_gap == 4'd0) begin
            r_state <= S_PULSE;
            r_out   <= 1'b1;
          end else begin
            r_gap <= r_gap - 4'd1;
          end
        end
        S_DONE, S_ERR: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_rem   <= '0;
          r_gap   <= 4'd0;
          r_out   <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign out       = r_out;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign pos       = r_pos;
  assign term      = r_term;
  assign bus.ready = r_ready;

endmodule

// File: tb/tb_d_c10_tx.sv
// Bench for d_c10_tx: two instances (GAP=1 and GAP=0) checked every cycle
// against a cycle-schedule model, plus hand-computed spot checks.
module tb_d_c10_tx;
  localparam int MAXC = 4000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       vld   [2];
  logic       clr_t [2];
  logic [3:0] dig   [2];
  logic       out_w [2];
  logic       busy_w[2];
  logic       done_w[2];
  logic       err_w [2];
  logic       term_w[2];
  logic       rdy_w [2];
  logic [3:0] pos_w [2];

  d_c10_tx_if if0();
  d_c10_tx_if if1();
  assign if0.valid = vld[0];
  assign if0.digit = dig[0];
  assign rdy_w[0]  = if0.ready;
  assign if1.valid = vld[1];
  assign if1.digit = dig[1];
  assign rdy_w[1]  = if1.ready;

  d_c10_tx #(.GAP(1), .CW(4)) dut_g1 (
    .clk(clk), .rst(rst), .bus(if0), .clr(clr_t[0]),
    .out(out_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]),
    .pos(pos_w[0]), .term(term_w[0])
  );

  d_c10_tx #(.GAP(0), .CW(5)) dut_g0 (
    .clk(clk), .rst(rst), .bus(if1), .clr(clr_t[1]),
    .out(out_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]),
    .pos(pos_w[1]), .term(term_w[1])
  );

  // ---------------- model: expected outputs per cycle ----------------
  // Cycle c is the clock period following rising edge number c.
  bit e_out [2][MAXC];
  bit e_busy[2][MAXC];
  bit e_done[2][MAXC];
  bit e_err [2][MAXC];
  int idle_from[2] = '{0, 0};
  int m_pos[2]     = '{0, 0};
  int rcv          = 0;   // downstream mod-10 counter fed by the GAP=0 instance
  int cyc          = 0;
  int vectors      = 0;
  int miscompares  = 0;

  function automatic int gap_of(int d);
    return (d == 0) ? 1 : 0;
  endfunction

  // Transfer at edge e of digit n: lay out the whole burst on the timeline.
  function automatic void schedule(int d, int e, int n);
    int g;
    int last;
    g = gap_of(d);
    if (n == 0) begin
      if (e < MAXC) e_done[d][e] = 1'b1;
      idle_from[d] = e + 1;
    end else if (n > 9) begin
      if (e < MAXC) e_err[d][e] = 1'b1;
      idle_from[d] = e + 1;
    end else begin
      last = e + (n - 1) * (g + 1);
      for (int k = 0; k < n; k++)
        if (e + k * (g + 1) < MAXC) e_out[d][e + k * (g + 1)] = 1'b1;
      for (int c = e; c <= last; c++)
        if (c < MAXC) e_busy[d][c] = 1'b1;
      if (last + 1 < MAXC) e_done[d][last + 1] = 1'b1;
      idle_from[d] = last + 2;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        if (cyc < MAXC) begin
          if (clr_t[d]) m_pos[d] = 0;
          else if (e_out[d][cyc]) m_pos[d] = (m_pos[d] + 1) % 10;
        end
        if (vld[d] && cyc >= idle_from[d]) schedule(d, cyc + 1, int'(dig[d]));
      end
      rcv = (rcv + int'(out_w[1])) % 10;
    end else begin
      rcv = 0;
    end
    cyc = cyc + 1;
  end

  // Reset abandons every scheduled event from the current cycle onward.
  always @(negedge rst) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = cyc; c < MAXC; c++) begin
        e_out[d][c]  = 1'b0;
        e_busy[d][c] = 1'b0;
        e_done[d][c] = 1'b0;
        e_err[d][c]  = 1'b0;
      end
      idle_from[d] = cyc;
      m_pos[d]     = 0;
    end
    rcv = 0;
  end

  task automatic chk(string name, int d, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, d, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      for (int d = 0; d < 2; d++) begin
        chk("out",   d, 8'(out_w[d]),  8'(e_out[d][cyc]));
        chk("busy",  d, 8'(busy_w[d]), 8'(e_busy[d][cyc]));
        chk("done",  d, 8'(done_w[d]), 8'(e_done[d][cyc]));
        chk("err",   d, 8'(err_w[d]),  8'(e_err[d][cyc]));
        chk("ready", d, 8'(rdy_w[d]),  8'(cyc >= idle_from[d]));
        chk("pos",   d, 8'(pos_w[d]),  8'(m_pos[d]));
        chk("term",  d, 8'(term_w[d]), 8'(m_pos[d] == 9));
      end
      chk("rcv_term", 1, 8'(term_w[1]), 8'(rcv == 9));
    end
  end

  // ---------------- stimulus ----------------
  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic wait_ready(int d);
    int n;
    n = 0;
    while (rdy_w[d] !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout dut%0d cycle %0d: got ready=%0b expected 1", d, cyc, rdy_w[d]);
    end
  endtask

  task automatic send(int d, int v);
    wait_ready(d);
    vld[d] = 1'b1;
    dig[d] = 4'(v);
    @(posedge clk); #1;
    vld[d] = 1'b0;
  endtask

  int e;
  int cnt;

  initial begin
    vld   = '{1'b0, 1'b0};
    clr_t = '{1'b0, 1'b0};
    dig   = '{4'd0, 4'd0};
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Burst of 3 with GAP=1 right after reset.
    send(0, 3);
    e = cyc;
    @(negedge clk); chk("t1_out_p1", 0, 8'(out_w[0]), 8'd1); chk("t1_pos0", 0, 8'(pos_w[0]), 8'd0);
                    chk("t1_rdy",    0, 8'(rdy_w[0]), 8'd0);
    @(negedge clk); chk("t1_gap1",   0, 8'(out_w[0]), 8'd0); chk("t1_pos1", 0, 8'(pos_w[0]), 8'd1);
    @(negedge clk); chk("t1_out_p2", 0, 8'(out_w[0]), 8'd1);
    @(negedge clk); chk("t1_pos2",   0, 8'(pos_w[0]), 8'd2); chk("t1_busy", 0, 8'(busy_w[0]), 8'd1);
    @(negedge clk); chk("t1_out_p3", 0, 8'(out_w[0]), 8'd1);
    @(negedge clk); chk("t1_done",   0, 8'(done_w[0]), 8'd1); chk("t1_pos3", 0, 8'(pos_w[0]), 8'd3);
                    chk("t1_rdy_d",  0, 8'(rdy_w[0]), 8'd0);
    @(negedge clk); chk("t1_rdy_back", 0, 8'(rdy_w[0]), 8'd1);
    @(posedge clk); #1;

    // GAP=0: 9 back-to-back pulses wrap the receiver through 9, then one more.
    send(1, 9);
    repeat (10) @(negedge clk);
    chk("t2_term9", 1, 8'(term_w[1]), 8'd1);
    chk("t2_done",  1, 8'(done_w[1]), 8'd1);
    @(posedge clk); #1;
    send(1, 1);
    @(negedge clk); chk("t2_pulse", 1, 8'(out_w[1]), 8'd1);
    @(negedge clk); chk("t2_wrap",  1, 8'(pos_w[1]), 8'd0);
    @(posedge clk); #1;

    // Zero digit, then an illegal digit.
    send(0, 0);
    @(negedge clk); chk("t3_done0", 0, 8'(done_w[0]), 8'd1); chk("t3_pos", 0, 8'(pos_w[0]), 8'd3);
    @(posedge clk); #1;
    send(0, 12);
    @(negedge clk); chk("t3_err", 0, 8'(err_w[0]), 8'd1); chk("t3_nodone", 0, 8'(done_w[0]), 8'd0);
                    chk("t3_pos12", 0, 8'(pos_w[0]), 8'd3);
    @(posedge clk); #1;

    // valid held high through a burst of 5.
    wait_ready(0);
    vld[0] = 1'b1;
    dig[0] = 4'd5;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_w[0] === 1'b1) break;
      cnt += int'(out_w[0]);
    end
    chk("t4_pulses", 0, 8'(cnt), 8'd5);
    repeat (6) @(posedge clk);
    #1 vld[0] = 1'b0;

    // Reset during the third pulse of a 7-burst.
    send(0, 7);
    repeat (4) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk); chk("t5_out_rst", 0, 8'(out_w[0]), 8'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); chk("t5_pos", 0, 8'(pos_w[0]), 8'd0); chk("t5_rdy", 0, 8'(rdy_w[0]), 8'd1);
    @(posedge clk); #1;

    // clr on the edge ending the fifth pulse of an 8-burst (pos=4 there).
    send(0, 8);
    repeat (8) @(posedge clk);
    #1 clr_t[0] = 1'b1;
    @(negedge clk); chk("t6_pos4", 0, 8'(pos_w[0]), 8'd4); chk("t6_out", 0, 8'(out_w[0]), 8'd1);
    @(posedge clk); #1 clr_t[0] = 1'b0;
    @(negedge clk); chk("t6_clr", 0, 8'(pos_w[0]), 8'd0);
    repeat (6) @(negedge clk);
    chk("t6_done", 0, 8'(done_w[0]), 8'd1); chk("t6_pos3", 0, 8'(pos_w[0]), 8'd3);
    @(posedge clk); #1;

    // Random traffic on both instances, one reset pulse in the middle.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        vld[d] = ($urandom_range(0, 2) == 0);
        dig[d] = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      clr_t[0] = ($urandom_range(0, 24) == 0);
      if (i == 700) begin
        #2 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
      end
    end
    @(posedge clk); #1;
    vld   = '{1'b0, 1'b0};
    clr_t = '{1'b0, 1'b0};
    repeat (200) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/d_c10_tx.md
Name: d_c10_tx

Overview:
- Pulse-train transmitter for the mod-10 pulse counter (d_c10).
- Accepts one BCD digit (0-9) through a valid/ready handshake and emits exactly that many single-cycle pulses on out, spaced by GAP idle cycles.
- Keeps a shadow copy (pos) of the downstream counter's mod-10 state, so the sender knows when the receiver's terminal output is high without a return path.
- Sits between the digit source and the d_c10 input pin, sharing its clock.

Parameters:
- GAP, default 1: low cycles inserted between consecutive pulses of one burst. Legal range 0-15. With GAP=0 the pulses form one continuous high run.
- CW, default 4: width of the internal remaining-count register. Must be at least 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. rst=0 forces the reset state immediately. Release is sampled on clk.
- digit  input  4  burst length request (BCD).
- valid  input  1  digit is valid this cycle.
- ready  output  1  block can accept a digit this cycle.
- clr  input  1  synchronous clear of pos, for re-aligning with a downstream counter reset.
- out  output  1  pulse output to the counter's in.
- busy  output  1  burst in progress (state PULSE or GAP).
- done  output  1  one-cycle strobe: burst complete.
- err  output  1  one-cycle strobe: digit > 9 rejected.
- pos  output  4  shadow mod-10 count, range 0-9.
- term  output  1  equals (pos==9); mirrors the counter's out.

Behaviour:
- States: IDLE, PULSE, GAP, DONE, ERR. All outputs are Moore, decoded from registered state, remaining-count and pos. No combinational path from an input to any output.
- Reset (rst=0): state=IDLE, remaining=0, pos=0, gap counter=0. Output values: out=0, busy=0, done=0, err=0, term=0, ready=1.
- ready=1 only in IDLE. A transfer occurs on the rising edge where valid=1 and ready=1 (call it edge t).
- IDLE, on transfer:
  - digit 1-9: load remaining=digit, go to PULSE.
  - digit 0: go to DONE (no pulses).
  - digit 10-15: go to ERR (no pulses; pos unchanged).
- IDLE without a transfer: hold state.
- PULSE (out=1, busy=1), lasts exactly one cycle:
  - remaining decrements by 1.
  - pos advances by 1, with 9 wrapping to 0.
  - If the new remaining is 0, go to DONE.
  - Else if GAP=0, stay in PULSE.
  - Else go to GAP with the gap counter loaded to GAP-1.
- GAP (out=0, busy=1): stay GAP cycles total, then go to PULSE.
- DONE: done=1 for one cycle, ready=0, then IDLE.
- ERR: err=1 for one cycle, ready=0, then IDLE.
- Timing for a burst of N (1-9) accepted at edge t:
  - Pulse k (k=1..N) is high in cycle t+1+(k-1)*(GAP+1).
  - done is high in the cycle after the last pulse.
  - The next transfer can occur at the earliest one cycle after done.
- Digit 0: done is high in cycle t+1.
- Digit > 9: err is high in cycle t+1.
- pos tracking:
  - pos updates on the same edge the downstream counter samples the pulse.
  - Therefore pos always equals the counter's present state when both come out of reset together.
  - term=1 exactly when the counter's out=1.
- clr=1 at an edge sets pos=0. It overrides a simultaneous pulse increment and does not affect state, remaining or out.
- digit and valid are ignored while ready=0; holding valid high does not queue a request.
- rst asserted mid-burst: out drops to 0 immediately (asynchronous). The burst is abandoned, with no done strobe.
- remaining never underflows. The PULSE-to-DONE decision uses remaining==1 before the decrement.

Test Plan:
- Reset, then digit=3 at edge t with GAP=1 -> out high in cycles t+1, t+3, t+5; done in t+6; pos steps 1, 2, 3; busy high for cycles t+1..t+5; ready low from t+1 to t+6.
- With GAP=0, send digit=9 then digit=1, connected to a d_c10 instance -> out high for 9 consecutive cycles then 1 more pulse; pos passes through 9 (term=1, matching the receiver's out=1) and wraps to 0; term and the receiver's out agree in every cycle.
- digit=0, then digit=12 -> done at t+1 with no pulse and pos unchanged; then err at t'+1 with no pulse, done=0 and pos unchanged.
- valid held high with digit=5 during an active burst -> no second burst starts until IDLE; exactly 5 pulses before the first done.
- Drop rst low during the third pulse of digit=7 -> out=0 in the same cycle; after release pos=0, ready=1, and no done or err strobe.
- clr=1 on the edge of a pulse with pos=4 -> pos=0 after that edge; the burst continues and the remaining pulses count from 0.
